// File: rtl/dot_pkg.sv
// Shared constants and types for the dot-location table and its MMIO decode.
package dot_pkg;
    localparam int DEF_NUM_DOTS = 450;
    localparam int DEF_H_RES    = 640;
    localparam int DEF_V_RES    = 480;
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_ID_W     = 10;

    // Word offsets of the X and Y tables in the processor's MMIO window.
    localparam logic [31:0] MMIO_X_BASE = 32'd100;
    localparam logic [31:0] MMIO_Y_BASE = 32'd550;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } scan_state_e;
endpackage

// File: rtl/dot_table_if.sv
// MMIO write path and optional readback path into the dot table.
interface dot_table_if import dot_pkg::*; #(
    parameter int ID_W = DEF_ID_W
);
    logic            dot_wren;
    logic            is_yloc;
    logic [ID_W-1:0] dot_id;
    logic [31:0]     dot_loc;
    logic            rd_en;
    logic            rd_yloc;
    logic [ID_W-1:0] rd_id;
    logic [31:0]     rd_data;
    logic            rd_valid;

    modport master (
        output dot_wren, is_yloc, dot_id, dot_loc, rd_en, rd_yloc, rd_id,
        input  rd_data, rd_valid
    );
    modport slave (
        input  dot_wren, is_yloc, dot_id, dot_loc, rd_en, rd_yloc, rd_id,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/dot_line_buffer.sv
// Ping-pong FRONT/BACK 1-bpp line images: swap+clear, bit set into BACK, registered FRONT lookup.
module dot_line_buffer import dot_pkg::*; #(
    parameter int H_RES   = DEF_H_RES,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               swap,
    input  logic               set_en,
    input  logic [COORD_W-1:0] set_x,
    input  logic [COORD_W-1:0] pix_x,
    output logic               pix_on
);
    logic [H_RES-1:0] buf0_q, buf0_d, buf1_q, buf1_d, front;
    logic             front_sel_q, front_sel_d;
    logic             pix_on_q, pix_on_d;

    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        front_sel_d = front_sel_q;
        // A swap takes priority over a late bit set from an abandoned build.
        if (swap) begin
            front_sel_d = ~front_sel_q;
            if (front_sel_q) buf1_d = '0;
            else             buf0_d = '0;
        end else if (set_en && (set_x < COORD_W'(H_RES))) begin
            if (front_sel_q) buf0_d[set_x] = 1'b1;
            else             buf1_d[set_x] = 1'b1;
        end
        front    = front_sel_q ? buf1_q : buf0_q;
        pix_on_d = (pix_x < COORD_W'(H_RES)) ? front[pix_x] : 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            front_sel_q <= 1'b0;
            pix_on_q    <= 1'b0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            front_sel_q <= front_sel_d;
            pix_on_q    <= pix_on_d;
        end
    end

    assign pix_on = pix_on_q;
endmodule

// File: rtl/dot_table.sv
// Dot X/Y coordinate table with per-line scan into a ping-pong line image.
// Optional readback port enabled by DOT_TABLE_READBACK_EN.
module dot_table import dot_pkg::*; #(
    parameter int NUM_DOTS = DEF_NUM_DOTS,
    parameter int H_RES    = DEF_H_RES,
    parameter int V_RES    = DEF_V_RES,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int ID_W     = DEF_ID_W
) (
    input  logic               clock,
    input  logic               reset,
    dot_table_if.slave         bus,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_num,
    input  logic [COORD_W-1:0] pix_x,
    output logic               pix_on,
    output logic               scan_busy,
    output logic               overrun
);
    localparam int IDX_W = $clog2(NUM_DOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);

    logic [COORD_W-1:0] x_mem [NUM_DOTS];
    logic [COORD_W-1:0] y_mem [NUM_DOTS];
    logic [NUM_DOTS-1:0] xv_q, xv_d, yv_q, yv_d;
    logic               wr_ok;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_loc, tgt_next, tgt_q, scan_x_p1, scan_y_p1;
    logic [IDX_W-1:0]   idx_q;
    scan_state_e        state_q;
    logic               busy_q, overrun_q, pend_q, set_en;
    logic               unused_loc_hi;

    assign unused_loc_hi = ^bus.dot_loc[31:COORD_W];

    always_comb begin
        wr_ok    = bus.dot_wren && (bus.dot_id < ID_W'(NUM_DOTS));
        wr_idx   = bus.dot_id[IDX_W-1:0];
        wr_loc   = bus.dot_loc[COORD_W-1:0];
        xv_d     = xv_q;
        yv_d     = yv_q;
        if (wr_ok && !bus.is_yloc) xv_d[wr_idx] = 1'b1;
        if (wr_ok &&  bus.is_yloc) yv_d[wr_idx] = 1'b1;
        tgt_next = (line_num == COORD_W'(V_RES - 1)) ? '0 : line_num + 1'b1;
        set_en   = pend_q && (scan_y_p1 == tgt_q);
    end

    // Read-first arrays: a same-cycle write is seen by the scan only on the next line.
    always_ff @(posedge clock) begin
        if (wr_ok && !bus.is_yloc) x_mem[wr_idx] <= wr_loc;
        if (wr_ok &&  bus.is_yloc) y_mem[wr_idx] <= wr_loc;
        scan_x_p1 <= x_mem[idx_q];
        scan_y_p1 <= y_mem[idx_q];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tgt_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            pend_q    <= 1'b0;
            xv_q      <= '0;
            yv_q      <= '0;
        end else begin
            xv_q   <= xv_d;
            yv_q   <= yv_d;
            pend_q <= 1'b0;
            if (line_start) begin
                if (state_q != ST_IDLE) overrun_q <= 1'b1;
                state_q <= ST_SCAN;
                idx_q   <= '0;
                tgt_q   <= tgt_next;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_SCAN: begin
                        pend_q <= xv_q[idx_q] & yv_q[idx_q];
                        if (idx_q == LAST_IDX) state_q <= ST_DRAIN;
                        else                   idx_q   <= idx_q + 1'b1;
                    end
                    ST_DRAIN: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    dot_line_buffer #(.H_RES(H_RES), .COORD_W(COORD_W)) u_line_buf (
        .clock  (clock),
        .reset  (reset),
        .swap   (line_start),
        .set_en (set_en),
        .set_x  (scan_x_p1),
        .pix_x  (pix_x),
        .pix_on (pix_on)
    );

    assign scan_busy = busy_q;
    assign overrun   = overrun_q;

`ifdef DOT_TABLE_READBACK_EN
    logic [COORD_W-1:0] rd_x_p1, rd_y_p1;
    logic               rd_vld_p1_q, rd_inr_p1_q, rd_sel_y_p1_q;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        rd_data_q, rd_data_d;

    always_ff @(posedge clock) begin
        rd_x_p1 <= x_mem[bus.rd_id[IDX_W-1:0]];
        rd_y_p1 <= y_mem[bus.rd_id[IDX_W-1:0]];
    end

    always_comb begin
        rd_valid_d = rd_vld_p1_q;
        rd_data_d  = '0;
        if (rd_vld_p1_q && rd_inr_p1_q)
            rd_data_d = {{(32 - COORD_W){1'b0}}, (rd_sel_y_p1_q ? rd_y_p1 : rd_x_p1)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_vld_p1_q   <= 1'b0;
            rd_inr_p1_q   <= 1'b0;
            rd_sel_y_p1_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            rd_vld_p1_q   <= bus.rd_en;
            rd_inr_p1_q   <= bus.rd_id < ID_W'(NUM_DOTS);
            rd_sel_y_p1_q <= bus.rd_yloc;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd    = ^{bus.rd_en, bus.rd_yloc, bus.rd_id};
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = '0;
`endif
endmodule
